// File: rtl/rob_mc_pkg.sv
// rtl/rob_mc_pkg.sv - shared ROB kind encodings and default sizing
package rob_mc_pkg;
    localparam int ROB_DEPTH = 16;
    localparam int ROB_IDX_W = 4;

    localparam logic [2:0] ROB_K_ALU    = 3'd0;
    localparam logic [2:0] ROB_K_LOAD   = 3'd1;
    localparam logic [2:0] ROB_K_STORE  = 3'd2;
    localparam logic [2:0] ROB_K_BRANCH = 3'd3;
    localparam logic [2:0] ROB_K_DIRECT = 3'd4;

    function automatic logic kind_writes_rd(input logic [2:0] kind);
        return (kind == ROB_K_ALU) || (kind == ROB_K_LOAD) || (kind == ROB_K_DIRECT);
    endfunction
endpackage

// File: rtl/rob_mc_lookup.sv
// rtl/rob_mc_lookup.sv - one operand read port: stored result first, else lowest matching CDB channel
module rob_mc_lookup
    import rob_mc_pkg::*;
#(
    parameter int DEPTH   = ROB_DEPTH,
    parameter int IDX_W   = ROB_IDX_W,
    parameter int NUM_CDB = 2
) (
    input  logic [IDX_W-1:0]         tag,
    input  logic [DEPTH-1:0]         done,
    input  logic [DEPTH-1:0][31:0]   value,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*IDX_W-1:0] cdb_tag,
    input  logic [NUM_CDB*32-1:0]    cdb_value,
    output logic                     ready,
    output logic [31:0]              result
);
    always_comb begin
        ready  = 1'b0;
        result = 32'd0;
        if (done[tag]) begin
            ready  = 1'b1;
            result = value[tag];
        end else begin
            // walk downwards so the lowest-index channel ends up winning
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
                if (cdb_valid[c] && cdb_tag[c*IDX_W +: IDX_W] == tag) begin
                    ready  = 1'b1;
                    result = cdb_value[c*32 +: 32];
                end
            end
        end
    end
endmodule

// File: rtl/rob_mc.sv
// rtl/rob_mc.sv - reorder buffer, N CDB channels, store handshake; ROB_PERF_EN adds retire/flush counters
module rob_mc
    import rob_mc_pkg::*;
#(
    parameter int DEPTH   = ROB_DEPTH,
    parameter int IDX_W   = ROB_IDX_W,
    parameter int NUM_CDB = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid_in,
    output logic                     issue_ready_out,
    input  logic [2:0]               issue_kind_in,
    input  logic [31:0]              issue_pc_in,
    input  logic [31:0]              issue_imm_in,
    input  logic [4:0]               issue_rd_in,
    input  logic [31:0]              issue_value_in,
    input  logic                     issue_pred_in,
    output logic [IDX_W-1:0]         issue_tag_out,
    input  logic [NUM_CDB-1:0]       cdb_valid_in,
    input  logic [NUM_CDB*IDX_W-1:0] cdb_tag_in,
    input  logic [NUM_CDB*32-1:0]    cdb_value_in,
    input  logic [NUM_CDB-1:0]       cdb_taken_in,
    input  logic [IDX_W-1:0]         q1_tag_in,
    input  logic [IDX_W-1:0]         q2_tag_in,
    output logic                     q1_ready_out,
    output logic                     q2_ready_out,
    output logic [31:0]              q1_value_out,
    output logic [31:0]              q2_value_out,
    output logic                     commit_valid_out,
    output logic [4:0]               commit_rd_out,
    output logic [IDX_W-1:0]         commit_tag_out,
    output logic [31:0]              commit_value_out,
    output logic                     store_commit_out,
    input  logic                     lsb_store_ack_in,
    output logic                     flush_out,
    output logic [31:0]              flush_pc_out,
    output logic [IDX_W:0]           count_out,
    output logic                     empty_out
`ifdef ROB_PERF_EN
    ,
    output logic [31:0]              perf_commit_cnt_out,
    output logic [31:0]              perf_flush_cnt_out
`endif
);
    logic [IDX_W-1:0]       head, tail;
    logic [IDX_W:0]         count;
    logic [DEPTH-1:0]       busy, done, pred, taken;
    logic [DEPTH-1:0][2:0]  kind;
    logic [DEPTH-1:0][4:0]  rd;
    logic [DEPTH-1:0][31:0] pc, imm, value;
    logic                   issue_acc, head_ready, retire;
    logic [2:0]             head_kind;

    assign issue_ready_out = rst_n_in && rdy_in && (count < (IDX_W+1)'(DEPTH));
    assign issue_acc       = issue_valid_in && issue_ready_out;
    assign issue_tag_out   = tail;
    assign head_ready      = rdy_in && busy[head] && done[head];
    assign head_kind       = kind[head];
    assign commit_tag_out  = head;
    assign count_out       = count;
    assign empty_out       = (count == '0);

    always_comb begin
        commit_valid_out = 1'b0;
        commit_rd_out    = 5'd0;
        commit_value_out = 32'd0;
        store_commit_out = 1'b0;
        flush_out        = 1'b0;
        flush_pc_out     = 32'd0;
        retire           = 1'b0;
        if (head_ready) begin
            if (head_kind == ROB_K_STORE) begin
                store_commit_out = 1'b1;
                retire           = lsb_store_ack_in;
            end else begin
                retire = 1'b1;
                if (kind_writes_rd(head_kind)) begin
                    commit_valid_out = 1'b1;
                    commit_rd_out    = rd[head];
                    commit_value_out = value[head];
                end else if (head_kind == ROB_K_BRANCH && taken[head] != pred[head]) begin
                    flush_out    = 1'b1;
                    flush_pc_out = taken[head] ? pc[head] + imm[head] : pc[head] + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
        end else if (rdy_in) begin
            if (flush_out) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                busy  <= '0;
                done  <= '0;
            end else begin
                if (retire) begin
                    busy[head] <= 1'b0;
                    done[head] <= 1'b0;
                    head       <= head + IDX_W'(1);
                end
                if (issue_acc) begin
                    busy[tail] <= 1'b1;
                    done[tail] <= (issue_kind_in == ROB_K_DIRECT);
                    tail       <= tail + IDX_W'(1);
                end
                for (int c = 0; c < NUM_CDB; c++) begin
                    if (cdb_valid_in[c]) done[cdb_tag_in[c*IDX_W +: IDX_W]] <= 1'b1;
                end
                count <= count + (IDX_W+1)'(issue_acc) - (IDX_W+1)'(retire);
            end
        end
    end

    // payload needs no reset: every consumer is qualified by busy/done
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_out) begin
            if (issue_acc) begin
                kind[tail]  <= issue_kind_in;
                pc[tail]    <= issue_pc_in;
                imm[tail]   <= issue_imm_in;
                rd[tail]    <= issue_rd_in;
                pred[tail]  <= issue_pred_in;
                value[tail] <= issue_value_in;
                taken[tail] <= 1'b0;
            end
            for (int c = 0; c < NUM_CDB; c++) begin
                if (cdb_valid_in[c]) begin
                    value[cdb_tag_in[c*IDX_W +: IDX_W]] <= cdb_value_in[c*32 +: 32];
                    taken[cdb_tag_in[c*IDX_W +: IDX_W]] <= cdb_taken_in[c];
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_in) begin
        if (rst_n_in && rdy_in) begin
            for (int c = 0; c < NUM_CDB; c++) begin
                if (cdb_valid_in[c]) begin
                    if (!busy[cdb_tag_in[c*IDX_W +: IDX_W]] || done[cdb_tag_in[c*IDX_W +: IDX_W]])
                        $fatal(1, "rob_mc: CDB write to idle or completed entry");
                    for (int k = c + 1; k < NUM_CDB; k++) begin
                        if (cdb_valid_in[k] && cdb_tag_in[k*IDX_W +: IDX_W] == cdb_tag_in[c*IDX_W +: IDX_W])
                            $fatal(1, "rob_mc: two CDB channels share a tag");
                    end
                end
            end
        end
    end
`endif

`ifdef ROB_PERF_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            perf_commit_cnt_out <= 32'd0;
            perf_flush_cnt_out  <= 32'd0;
        end else begin
            if (retire)    perf_commit_cnt_out <= perf_commit_cnt_out + 32'd1;
            if (flush_out) perf_flush_cnt_out  <= perf_flush_cnt_out + 32'd1;
        end
    end
`else
    // no performance counters in this build
`endif

    rob_mc_lookup #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_CDB(NUM_CDB)) u_q1 (
        .tag(q1_tag_in), .done(done), .value(value), .cdb_valid(cdb_valid_in),
        .cdb_tag(cdb_tag_in), .cdb_value(cdb_value_in), .ready(q1_ready_out), .result(q1_value_out)
    );

    rob_mc_lookup #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_CDB(NUM_CDB)) u_q2 (
        .tag(q2_tag_in), .done(done), .value(value), .cdb_valid(cdb_valid_in),
        .cdb_tag(cdb_tag_in), .cdb_value(cdb_value_in), .ready(q2_ready_out), .result(q2_value_out)
    );
endmodule
